// File: rtl/uart_tx_core.sv
// UART 8N1/8E1 transmitter fed by a small TX FIFO; tx_o is a flop. Latency: byte pushed at edge E
// into an idle, empty core -> start bit at E+1. Backpressure: tx_ready_o low while the FIFO is full.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  output logic          push_rdy,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [LW-1:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;
  logic          push;

  assign push_rdy = (level_q != LW'(DEPTH));
  assign push     = push_vld & push_rdy;
  assign head_dat = mem[rd_ptr];
  assign level    = level_q;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module uart_tx_core #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DIV_WIDTH-1:0]             cfg_div_i,
  input  logic                             cfg_parity_en_i,
  input  logic [7:0]                       tx_data_i,
  input  logic                             tx_valid_i,
  output logic                             tx_ready_o,
  output logic                             tx_o,
  output logic                             busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_q, par_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  logic                 par_en_q, par_en_d;
  logic                 tx_q, tx_d;
  logic                 pop, bit_done;
  logic [7:0]           head;
  logic [LW-1:0]        level;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8), .LW(LW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (tx_valid_i),
    .push_dat (tx_data_i),
    .push_rdy (tx_ready_o),
    .pop      (pop),
    .head_dat (head),
    .level    (level)
  );

  assign bit_done = (cnt_q == div_q);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q + DIV_WIDTH'(1);
    div_d     = div_q;
    par_en_d  = par_en_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        pop   = (level != '0);
      end
      START: if (bit_done) begin
        state_d   = DATA;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
      DATA: if (bit_done) begin
        cnt_d     = '0;
        shift_d   = shift_q >> 1;
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (bit_done) begin
        state_d = STOP;
        cnt_d   = '0;
      end
      STOP: if (bit_done) begin
        cnt_d   = '0;
        state_d = IDLE;
        pop     = (level != '0);
      end
      default: state_d = IDLE;
    endcase
    // Frame start: config is frozen here for the whole frame.
    if (pop) begin
      state_d  = START;
      cnt_d    = '0;
      shift_d  = head;
      par_d    = ^head;
      div_d    = cfg_div_i;
      par_en_d = cfg_parity_en_i;
    end
    // Line value follows the state being entered so tx_o stays a pure flop output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != IDLE) | (level != '0);
  assign fifo_level_o = level;
endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: cycle-exact frame waveforms, FIFO backpressure, reset abort, config shadowing.
module tb_uart_tx_core;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_div_i;
  logic        cfg_parity_en_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic        tx_o;
  logic        busy_o;
  logic [2:0]  fifo_level_o;

  int          tests = 0;
  int          fails = 0;
  int          stalls = 0;
  logic [2:0]  lvl_at_stall = '0;
  logic [7:0]  msg[$];

  always #5 clk = ~clk;

  uart_tx_core #(.FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_div_i       (cfg_div_i),
    .cfg_parity_en_i (cfg_parity_en_i),
    .tx_data_i       (tx_data_i),
    .tx_valid_i      (tx_valid_i),
    .tx_ready_o      (tx_ready_o),
    .tx_o            (tx_o),
    .busy_o          (busy_o),
    .fifo_level_o    (fifo_level_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bit 0 is the start bit; bits go out in index order.
  function automatic logic [10:0] build_frame(input logic [7:0] b, input bit par);
    if (par) return {1'b1, ^b, b, 1'b0};
    return {1'b0, 1'b1, b, 1'b0};
  endfunction

  task automatic push_one(input logic [7:0] b);
    logic r;
    int   n = 0;
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    do begin
      r = tx_ready_o;
      if (!r) begin
        stalls++;
        lvl_at_stall = fifo_level_o;
      end
      @(posedge clk); #1;
      n++;
    end while (!r && n < 20000);
    if (!r) check("push timeout", 0, 1);
    tx_valid_i = 1'b0;
  endtask

  // Called one edge before the start bit appears; samples every cycle of the frame.
  task automatic expect_frame(input string tag, input logic [10:0] frame, input int nbits,
                              input int div, output logic [7:0] got);
    int bad = 0;
    got = '0;
    for (int j = 0; j < nbits; j++) begin
      for (int c = 0; c <= div; c++) begin
        @(posedge clk); #1;
        if (tx_o !== frame[j]) bad++;
        if (c == div / 2 && j >= 1 && j <= 8) got[j-1] = tx_o;
      end
    end
    check({tag, " wave"}, bad, 0);
    check({tag, " data"}, got, frame[8:1]);
  endtask

  task automatic stream(input string tag, input int div, input bit par,
                        input int new_div, input int change_at);
    string rx = "";
    cfg_div_i       = div[15:0];
    cfg_parity_en_i = par;
    fork
      begin
        for (int i = 0; i < msg.size(); i++) push_one(msg[i]);
      end
      begin
        logic [7:0] g;
        @(posedge clk); #1;
        for (int i = 0; i < msg.size(); i++) begin
          expect_frame($sformatf("%s f%0d", tag, i), build_frame(msg[i], par), par ? 11 : 10,
                       (i == 0 || change_at < 0) ? div : new_div, g);
          if (g != 8'h0a) rx = $sformatf("%s%c", rx, g);
        end
      end
      begin
        if (change_at >= 0) begin
          repeat (change_at) @(posedge clk);
          #1 cfg_div_i = new_div[15:0];
        end
      end
    join
    $display("RX string: %s", rx);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, " idle tx"}, tx_o, 1);
    check({tag, " idle busy"}, busy_o, 0);
    check({tag, " idle level"}, fifo_level_o, 0);
  endtask

  initial begin
    logic [7:0] g;
    int lows;
    rst_n = 1'b0;
    cfg_div_i = 16'd3;
    cfg_parity_en_i = 1'b0;
    tx_data_i = '0;
    tx_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst tx", tx_o, 1);
    check("rst ready", tx_ready_o, 1);
    check("rst busy", busy_o, 0);
    check("rst level", fifo_level_o, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 0x55, 8N1, 4-cycle bits
    push_one(8'h55);
    check("t1 level", fifo_level_o, 1);
    check("t1 busy", busy_o, 1);
    check("t1 tx before start", tx_o, 1);
    expect_frame("t1", 11'b01010101010, 10, 3, g);
    check("t1 busy in stop", busy_o, 1);
    idle_check("t1");

    // 0xA7, 8E1: parity bit 1
    cfg_parity_en_i = 1'b1;
    push_one(8'hA7);
    expect_frame("t2", 11'b11101001110, 11, 3, g);
    idle_check("t2");

    // six bytes through a 4-deep FIFO
    msg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    stalls = 0;
    stream("t3", 3, 1'b0, 3, -1);
    check("t3 stalled", (stalls > 0), 1);
    check("t3 level at stall", lvl_at_stall, 4);
    idle_check("t3");

    // divisor change mid-frame applies to the next frame only
    msg = '{8'h3C, 8'hC3};
    stream("t6", 3, 1'b0, 7, 12);
    idle_check("t6");

    // 115200 baud at 50 MHz
    msg = '{8'h48, 8'h69, 8'h0a};
    stream("t4", 433, 1'b0, 433, -1);
    idle_check("t4");

    // reset during data bit 3 with two bytes queued
    cfg_div_i = 16'd3;
    cfg_parity_en_i = 1'b0;
    push_one(8'h12);
    push_one(8'h34);
    push_one(8'h56);
    repeat (16) @(posedge clk);
    #1;
    check("t5 data bit3 low", tx_o, 0);
    check("t5 queued", fifo_level_o, 2);
    rst_n = 1'b0;
    #1;
    check("t5 rst tx", tx_o, 1);
    check("t5 rst level", fifo_level_o, 0);
    check("t5 rst ready", tx_ready_o, 1);
    check("t5 rst busy", busy_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (tx_o !== 1'b1) lows++;
    end
    check("t5 line idle after reset", lows, 0);
    idle_check("t5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
